// File: rtl/reg2axil.sv
//------------------------------------------------------------------------------
// reg2axil: AXI4-Lite master bridge, one outstanding single-beat register access.
// Optional macro REG2AXIL_ALIGN_CHECK_EN: reject misaligned requests locally.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg2axil #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

`ifdef REG2AXIL_ALIGN_CHECK_EN
  localparam int C_ALIGN_LSB = $clog2(STRB_WIDTH);
`endif

  state_t                state_q;
  logic                  req_ready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
`ifdef REG2AXIL_ALIGN_CHECK_EN
            if (req_addr[C_ALIGN_LSB-1:0] != '0) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RSP;
            end else
`endif
            if (req_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          // AW and W complete independently; a channel whose valid is low is already done.
          if (awvalid_q && m_axil_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil_wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (m_axil_bvalid) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= (m_axil_bresp != 2'b00);
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RADDR: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (m_axil_rvalid) begin
            rready_q    <= 1'b0;
            rsp_err_q   <= (m_axil_rresp != 2'b00);
            rsp_rdata_q <= m_axil_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_reg2axil.sv
//------------------------------------------------------------------------------
// tb_reg2axil: directed self-checking bench for the reg2axil AXI-Lite master.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg2axil;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

  reg2axil dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters, sampled on the active edge.
  always @(posedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
    if (bvalid && bready)   b_hs++;
    if (arvalid && arready) ar_hs++;
    if (rvalid && rready)   r_hs++;
  end

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
  endtask

  task automatic clear_counts();
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 7'b0) begin failures++;
      $display("FAIL rst_handshakes got=%07b exp=0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}); end
    checks++; if ({rsp_rdata, awaddr, wdata, wstrb} !== 100'b0) begin failures++;
      $display("FAIL rst_data got=%h/%h/%h/%h exp=0", rsp_rdata, awaddr, wdata, wstrb); end
    checks++; if ({awprot, arprot} !== 6'b0) begin failures++; $display("FAIL rst_prot got=%b/%b exp=000", awprot, arprot); end
    rst_n = 1;
  endtask

  task automatic test_write_basic();
    @(negedge clk);
    clear_counts();
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
    awready = 1; wready = 1;
    @(posedge clk);               // cycle 0: accept
    @(negedge clk);
    req_valid = 0;
    checks++; if ({awvalid, wvalid, req_ready} !== 3'b110) begin failures++; $display("FAIL wb_valids got=%03b exp=110", {awvalid, wvalid, req_ready}); end
    checks++; if (awaddr !== 32'h10 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin failures++;
      $display("FAIL wb_payload got=%h/%h/%h exp=10/deadbeef/f", awaddr, wdata, wstrb); end
    @(posedge clk);               // cycle 1: AW/W handshake
    @(negedge clk);
    awready = 0; wready = 0;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin failures++; $display("FAIL wb_after_aw got=%03b exp=001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    @(posedge clk);               // cycle 2: B
    @(negedge clk);
    bvalid = 0;
    checks++; if ({rsp_valid, rsp_err, bready} !== 3'b100 || rsp_rdata !== 32'h0) begin failures++;
      $display("FAIL wb_rsp got=v%0b e%0b br%0b d=%h exp=v1 e0 br0 d=0", rsp_valid, rsp_err, bready, rsp_rdata); end
    checks++; if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin failures++; $display("FAIL wb_hs_count got=%0d/%0d/%0d exp=1/1/1", aw_hs, w_hs, b_hs); end
    @(posedge clk);               // cycle 3: rsp consumed
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL wb_back_idle got=%02b exp=01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_write_wdelay();
    @(negedge clk);
    clear_counts();
    req_valid = 1; req_we = 1; req_addr = 32'h44; req_wdata = 32'h0BADF00D; req_wstrb = 4'h3;
    awready = 1; wready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);               // AW handshake only
    @(negedge clk);
    awready = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'h0BADF00D || wstrb !== 4'h3) begin failures++;
        $display("FAIL wd_hold%0d got=%03b d=%h s=%h exp=010 d=0badf00d s=3", i, {awvalid, wvalid, bready}, wdata, wstrb); end
      if (i == 2) wready = 1;
      @(posedge clk);
      @(negedge clk);
    end
    wready = 0;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin failures++; $display("FAIL wd_after_w got=%03b exp=001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL wd_rsp got=v%0b e%0b exp=v1 e0", rsp_valid, rsp_err); end
    checks++; if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin failures++; $display("FAIL wd_hs_count got=%0d/%0d/%0d exp=1/1/1", aw_hs, w_hs, b_hs); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL wd_single_rsp got=%02b exp=01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_read_stall();
    @(negedge clk);
    clear_counts();
    req_valid = 1; req_we = 0; req_addr = 32'h20;
    arready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h20 || rready !== 1'b0) begin failures++;
        $display("FAIL rs_ar_hold%0d got=v%0b a=%h rr%0b exp=v1 a=20 rr0", i, arvalid, araddr, rready); end
      if (i == 2) arready = 1;
      @(posedge clk);
      @(negedge clk);
    end
    arready = 0;
    checks++; if ({arvalid, rready} !== 2'b01) begin failures++; $display("FAIL rs_after_ar got=%02b exp=01", {arvalid, rready}); end
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin failures++;
      $display("FAIL rs_rsp got=v%0b d=%h e%0b exp=v1 d=12345678 e0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (ar_hs !== 1 || r_hs !== 1) begin failures++; $display("FAIL rs_hs_count got=%0d/%0d exp=1/1", ar_hs, r_hs); end
    @(posedge clk);
  endtask

  task automatic test_read_slverr();
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h30;
    arready = 1;
    @(posedge clk);               // accept
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);               // AR handshake
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rvalid = 0; rresp = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin failures++;
      $display("FAIL se_rsp got=v%0b e%0b d=%h exp=v1 e1 d=cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_rsp_backpressure();
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h40;
    arready = 1; rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h50;            // keep a second request pending throughout
    @(posedge clk);
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'hA5A55A5A;
    @(posedge clk);
    @(negedge clk);
    rvalid = 0; rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A55A5A || req_ready !== 1'b0) begin failures++;
        $display("FAIL bp_hold%0d got=v%0b d=%h rq%0b exp=v1 d=a5a55a5a rq0", i, rsp_valid, rsp_rdata, req_ready); end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1;
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hs_cycle got=rq%0b v%0b exp=rq0 v1", req_ready, rsp_valid); end
    @(posedge clk);               // rsp handshake
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready, arvalid} !== 3'b010) begin failures++; $display("FAIL bp_release got=%03b exp=010", {rsp_valid, req_ready, arvalid}); end
    req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({arvalid, req_ready} !== 2'b01) begin failures++; $display("FAIL bp_no_accept got=%02b exp=01", {arvalid, req_ready}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h60; req_wdata = 32'h1; req_wstrb = 4'h1;
    awready = 0; wready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checks++; if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL rm_pre got=%02b exp=11", {awvalid, wvalid}); end
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready} !== 7'b0000001) begin failures++;
      $display("FAIL rm_post got=%07b exp=0000001", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready}); end
  endtask

`ifdef REG2AXIL_ALIGN_CHECK_EN
  task automatic test_align();
    @(negedge clk);
    clear_counts();
    req_valid = 1; req_we = 0; req_addr = 32'h22;
    arready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checks++; if (arvalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++;
      $display("FAIL al_rsp got=ar%0b v%0b e%0b d=%h exp=ar0 v1 e1 d=0", arvalid, rsp_valid, rsp_err, rsp_rdata); end
    @(posedge clk);
    @(negedge clk);
    arready = 0;
    checks++; if (ar_hs !== 0 || req_ready !== 1'b1) begin failures++; $display("FAIL al_no_ar got=hs%0d rq%0b exp=hs0 rq1", ar_hs, req_ready); end
  endtask
`else
  task automatic test_align();
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h22;
    arready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h22 || rsp_valid !== 1'b0) begin failures++;
      $display("FAIL al_pass got=ar%0b a=%h v%0b exp=ar1 a=22 v0", arvalid, araddr, rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'h00C0FFEE;
    @(posedge clk);
    @(negedge clk);
    rvalid = 0;
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h00C0FFEE) begin failures++;
      $display("FAIL al_rsp got=e%0b d=%h exp=e0 d=00c0ffee", rsp_err, rsp_rdata); end
    @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_write_wdelay();
    test_read_stall();
    test_read_slverr();
    test_rsp_backpressure();
    test_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
